// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller for the MEM stage.
// Hits complete combinationally; misses stall the pipeline while a line is written back and/or filled.
module dcache_ctrl #(
  parameter int NUM_LINES  = 32,
  parameter int LINE_BYTES = 32,
  localparam int IDX_W     = $clog2(NUM_LINES),
  localparam int TAG_W     = 27 - IDX_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_read_i,
  input  logic         cpu_write_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_wdata_i,
  output logic [31:0]  cpu_rdata_o,
  output logic         stall_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_wdata_o,
  input  logic         mem_ack_i,
  input  logic [255:0] mem_rdata_i
);

  localparam int WORDS = LINE_BYTES / 4;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_t;

  state_t state_reg, state_next;

  logic [NUM_LINES-1:0] valid_reg, dirty_reg;
  logic [TAG_W-1:0]     tag_mem [NUM_LINES];

  logic                 mem_req_reg, mem_req_next;
  logic                 mem_we_reg, mem_we_next;
  logic [31:0]          mem_addr_reg, mem_addr_next;
  logic [255:0]         mem_wdata_reg, mem_wdata_next;

  logic [IDX_W-1:0]     idx;
  logic [TAG_W-1:0]     cpu_tag;
  logic [TAG_W-1:0]     tag_rd;
  logic [2:0]           word_sel;
  logic [255:0]         line_rd;
  logic [31:0]          cpu_word;
  logic [31:0]          fill_addr;
  logic                 hit;
  logic                 stall_int;
  logic                 store_hit;
  logic                 fill_en;
  logic                 addr_unused;

  assign idx         = cpu_addr_i[5 +: IDX_W];
  assign cpu_tag     = cpu_addr_i[31 -: TAG_W];
  assign word_sel    = cpu_addr_i[4:2];
  assign addr_unused = ^cpu_addr_i[1:0];
  assign tag_rd      = tag_mem[idx];
  assign hit         = valid_reg[idx] && (tag_rd == cpu_tag);
  assign fill_addr   = {cpu_tag, idx, 5'b0};
  assign cpu_word    = line_rd[{word_sel, 5'b0} +: 32];

  // One word-wide bank per word of the line so a store touches only its own word.
  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_bank
      logic [31:0] bank_mem [NUM_LINES];

      always_ff @(posedge clk_i) begin
        if (fill_en) begin
          bank_mem[idx] <= mem_rdata_i[gi*32 +: 32];
        end else if (store_hit && (word_sel == 3'(gi))) begin
          bank_mem[idx] <= cpu_wdata_i;
        end
      end

      assign line_rd[gi*32 +: 32] = bank_mem[idx];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      tag_mem[idx] <= cpu_tag;
    end
  end

  always_comb begin
    state_next     = state_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    stall_int      = 1'b0;
    store_hit      = 1'b0;
    fill_en        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cpu_read_i || cpu_write_i) begin
          if (hit) begin
            store_hit = cpu_write_i;
          end else begin
            stall_int    = 1'b1;
            mem_req_next = 1'b1;
            if (valid_reg[idx] && dirty_reg[idx]) begin
              state_next     = WRITEBACK;
              mem_we_next    = 1'b1;
              mem_addr_next  = {tag_rd, idx, 5'b0};
              mem_wdata_next = line_rd;
            end else begin
              state_next    = ALLOCATE;
              mem_we_next   = 1'b0;
              mem_addr_next = fill_addr;
            end
          end
        end
      end
      WRITEBACK: begin
        stall_int = 1'b1;
        if (mem_ack_i) begin
          state_next    = ALLOCATE;
          mem_we_next   = 1'b0;
          mem_addr_next = fill_addr;
        end
      end
      ALLOCATE: begin
        stall_int = 1'b1;
        if (mem_ack_i) begin
          fill_en      = 1'b1;
          mem_req_next = 1'b0;
          state_next   = REFILL;
        end
      end
      REFILL: begin
        stall_int  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg     <= IDLE;
      valid_reg     <= '0;
      dirty_reg     <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      if (fill_en) begin
        valid_reg[idx] <= 1'b1;
        dirty_reg[idx] <= 1'b0;
      end else if (store_hit) begin
        dirty_reg[idx] <= 1'b1;
      end
    end
  end

  // Combinational outputs are forced quiet while reset is held.
  assign stall_o     = rst_i & stall_int;
  assign cpu_rdata_o = (rst_i && hit) ? cpu_word : 32'h0;
  assign mem_req_o   = mem_req_reg;
  assign mem_we_o    = mem_we_reg;
  assign mem_addr_o  = mem_addr_reg;
  assign mem_wdata_o = mem_wdata_reg;

endmodule
